// File: rtl/mem_lsu_if.sv
// SRAM-like data bus between the MEM-stage LSU and the data memory.
// Request fields are held stable by the master until addr_ok.
interface mem_lsu_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [3:0]        data_wstrb;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size,
    output data_addr, data_wstrb, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size,
    input  data_addr, data_wstrb, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: one bus access per bundle, stalls until
// completion, aligns/extends load data and flags misaligned addresses.
module mem_lsu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        mem_op_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] store_data_i,
  input  logic              flush_i,
  input  logic              mem_adv_i,
  mem_lsu_if.master         bus,
  output logic              stall_req_o,
  output logic [DATA_W-1:0] ld_data_o,
  output logic              done_o,
  output logic              adel_o,
  output logic              ades_o,
  output logic [ADDR_W-1:0] badvaddr_o
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE, S_REQ, S_WAIT, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic              cncl_q, cncl_d;
  logic [3:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] ld_q, ld_d;

  logic in_ld, in_st, in_half, in_word, in_mis;
  logic [1:0]        q_size;
  logic [3:0]        q_wstrb;
  logic [DATA_W-1:0] q_wdata, ld_ext;
  logic [7:0]        rd_b;
  logic [15:0]       rd_h;

  assign in_ld   = (mem_op_i >= OP_LB) && (mem_op_i <= OP_LW);
  assign in_st   = (mem_op_i >= OP_SB) && (mem_op_i <= OP_SW);
  assign in_half = (mem_op_i == OP_LH) || (mem_op_i == OP_LHU)
                || (mem_op_i == OP_SH);
  assign in_word = (mem_op_i == OP_LW) || (mem_op_i == OP_SW);
  assign in_mis  = (in_half && mem_addr_i[0])
                || (in_word && (mem_addr_i[1:0] != 2'b00));

  always_comb begin
    q_size  = 2'd0;
    q_wstrb = 4'b0000;
    q_wdata = wdata_q;
    unique case (1'b1)
      (op_q == OP_SB): begin
        q_wstrb = 4'b0001 << addr_q[1:0];
        q_wdata = {4{wdata_q[7:0]}};
      end
      (op_q == OP_SH): begin
        q_size  = 2'd1;
        q_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
        q_wdata = {2{wdata_q[15:0]}};
      end
      (op_q == OP_SW): begin
        q_size  = 2'd2;
        q_wstrb = 4'b1111;
      end
      (op_q == OP_LH),
      (op_q == OP_LHU): q_size = 2'd1;
      (op_q == OP_LW):  q_size = 2'd2;
      default: ;
    endcase
  end

  always_comb begin
    rd_h = addr_q[1] ? bus.data_rdata[31:16]
                     : bus.data_rdata[15:0];
    unique case (addr_q[1:0])
      2'd0:    rd_b = bus.data_rdata[7:0];
      2'd1:    rd_b = bus.data_rdata[15:8];
      2'd2:    rd_b = bus.data_rdata[23:16];
      default: rd_b = bus.data_rdata[31:24];
    endcase
    unique case (op_q)
      OP_LB:   ld_ext = {{24{rd_b[7]}}, rd_b};
      OP_LBU:  ld_ext = {24'd0, rd_b};
      OP_LH:   ld_ext = {{16{rd_h[15]}}, rd_h};
      OP_LHU:  ld_ext = {16'd0, rd_h};
      default: ld_ext = bus.data_rdata;
    endcase
  end

  assign bus.data_req   = (state_q == S_REQ);
  assign bus.data_wr    = (op_q >= OP_SB) && (op_q <= OP_SW);
  assign bus.data_size  = q_size;
  assign bus.data_addr  = addr_q;
  assign bus.data_wstrb = q_wstrb;
  assign bus.data_wdata = q_wdata;
  assign ld_data_o      = ld_q;

  always_comb begin
    state_d     = state_q;
    cncl_d      = cncl_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    ld_d        = ld_q;
    stall_req_o = 1'b0;
    done_o      = 1'b0;
    adel_o      = 1'b0;
    ades_o      = 1'b0;
    badvaddr_o  = '0;
    unique case (state_q)
      S_IDLE: begin
        // the discarded response of a flushed op frees the bus
        if (cncl_q && bus.data_data_ok) cncl_d = 1'b0;
        if ((in_ld || in_st) && in_mis) begin
          adel_o     = in_ld;
          ades_o     = in_st;
          badvaddr_o = mem_addr_i;
        end else if (in_ld || in_st) begin
          if (cncl_q && !bus.data_data_ok) begin
            stall_req_o = 1'b1;
          end else if (!flush_i) begin
            stall_req_o = 1'b1;
            op_d        = mem_op_i;
            addr_d      = mem_addr_i;
            wdata_d     = store_data_i;
            state_d     = S_REQ;
          end
        end
      end
      S_REQ: begin
        stall_req_o = !cncl_q;
        if (flush_i) cncl_d = 1'b1;
        if (bus.data_addr_ok) begin
          if (cncl_q || flush_i) begin
            state_d = S_IDLE;
            if (bus.data_data_ok) cncl_d = 1'b0;
          end else if (bus.data_data_ok) begin
            state_d = S_DONE;
            ld_d    = ld_ext;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        stall_req_o = !cncl_q;
        if (bus.data_data_ok) begin
          if (cncl_q || flush_i) begin
            state_d = S_IDLE;
            cncl_d  = 1'b0;
          end else begin
            state_d = S_DONE;
            ld_d    = ld_ext;
          end
        end else if (flush_i) begin
          cncl_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        done_o = 1'b1;
        if (mem_adv_i || flush_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cncl_q  <= 1'b0;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      ld_q    <= '0;
    end else begin
      state_q <= state_d;
      cncl_q  <= cncl_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ld_q    <= ld_d;
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: loads, stores, misalignment, bus stalls,
// flush/cancel and mid-transaction reset.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  op;
  logic [31:0] addr, sdata;
  logic        flush, adv;
  logic        stall, done, adel, ades;
  logic [31:0] ld, badv;
  int          errors = 0;
  int          checks = 0;

  mem_lsu_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_op_i     (op),
    .mem_addr_i   (addr),
    .store_data_i (sdata),
    .flush_i      (flush),
    .mem_adv_i    (adv),
    .bus          (bus.master),
    .stall_req_o  (stall),
    .ld_data_o    (ld),
    .done_o       (done),
    .adel_o       (adel),
    .ades_o       (ades),
    .badvaddr_o   (badv)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // inputs change 2 time units after the rising edge
  task automatic nxt;
    @(posedge clk);
    #2;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req"},   32'(bus.data_req), 0);
    chk({tag, "_wr"},    32'(bus.data_wr), 0);
    chk({tag, "_size"},  32'(bus.data_size), 0);
    chk({tag, "_addr"},  bus.data_addr, 0);
    chk({tag, "_wstrb"}, 32'(bus.data_wstrb), 0);
    chk({tag, "_wdata"}, bus.data_wdata, 0);
    chk({tag, "_stall"}, 32'(stall), 0);
    chk({tag, "_done"},  32'(done), 0);
    chk({tag, "_ld"},    ld, 0);
    chk({tag, "_adel"},  32'(adel), 0);
    chk({tag, "_ades"},  32'(ades), 0);
    chk({tag, "_badv"},  badv, 0);
  endtask

  initial begin
    rst = 1'b0; op = 4'd0; addr = '0; sdata = '0;
    flush = 1'b0; adv = 1'b0;
    bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b0;
    bus.data_rdata   = '0;
    repeat (2) @(posedge clk);
    #3;
    chk_zero("rst");
    rst = 1'b1;

    // LB 0x80001003: byte 0x80 sign-extended
    nxt; op = 4'd1; addr = 32'h8000_1003; #1;
    chk("lb_c0_stall", 32'(stall), 1);
    chk("lb_c0_req", 32'(bus.data_req), 0);
    nxt; bus.data_addr_ok = 1'b1; #1;
    chk("lb_c1_req", 32'(bus.data_req), 1);
    chk("lb_c1_stall", 32'(stall), 1);
    chk("lb_c1_addr", bus.data_addr, 32'h8000_1003);
    chk("lb_c1_size", 32'(bus.data_size), 0);
    chk("lb_c1_wstrb", 32'(bus.data_wstrb), 0);
    chk("lb_c1_wr", 32'(bus.data_wr), 0);
    nxt; bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b1; bus.data_rdata = 32'h80FF_1234; #1;
    chk("lb_c2_req", 32'(bus.data_req), 0);
    chk("lb_c2_stall", 32'(stall), 1);
    chk("lb_c2_done", 32'(done), 0);
    nxt; bus.data_data_ok = 1'b0; adv = 1'b1; #1;
    chk("lb_c3_done", 32'(done), 1);
    chk("lb_c3_ld", ld, 32'hFFFF_FF80);
    chk("lb_c3_stall", 32'(stall), 0);

    // LBU same address: zero-extended
    nxt; adv = 1'b0; op = 4'd2; #1;
    chk("lbu_c0_stall", 32'(stall), 1);
    nxt; bus.data_addr_ok = 1'b1; #1;
    chk("lbu_c1_req", 32'(bus.data_req), 1);
    nxt; bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; #1;
    nxt; bus.data_data_ok = 1'b0; adv = 1'b1; #1;
    chk("lbu_done", 32'(done), 1);
    chk("lbu_ld", ld, 32'h0000_0080);

    // SH 0x100A: upper half lanes, same-cycle addr_ok/data_ok
    nxt; adv = 1'b0; op = 4'd7; addr = 32'h0000_100A;
    sdata = 32'h1234_ABCD; #1;
    nxt; bus.data_addr_ok = 1'b1; bus.data_data_ok = 1'b1; #1;
    chk("sh_req", 32'(bus.data_req), 1);
    chk("sh_wr", 32'(bus.data_wr), 1);
    chk("sh_size", 32'(bus.data_size), 1);
    chk("sh_wstrb", 32'(bus.data_wstrb), 32'hC);
    chk("sh_wdata", bus.data_wdata, 32'hABCD_ABCD);
    nxt; bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
    adv = 1'b1; #1;
    chk("sh_done", 32'(done), 1);

    // SB 0x1001
    nxt; adv = 1'b0; op = 4'd6; addr = 32'h0000_1001;
    sdata = 32'h0000_0055; #1;
    nxt; bus.data_addr_ok = 1'b1; bus.data_data_ok = 1'b1; #1;
    chk("sb_wstrb", 32'(bus.data_wstrb), 32'h2);
    chk("sb_wdata", bus.data_wdata, 32'h5555_5555);
    chk("sb_size", 32'(bus.data_size), 0);
    nxt; bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
    adv = 1'b1; #1;
    chk("sb_done", 32'(done), 1);

    // misaligned LW / SW
    nxt; adv = 1'b0; op = 4'd5; addr = 32'h0000_1002; #1;
    chk("lw_mis_adel", 32'(adel), 1);
    chk("lw_mis_ades", 32'(ades), 0);
    chk("lw_mis_badv", badv, 32'h0000_1002);
    chk("lw_mis_stall", 32'(stall), 0);
    chk("lw_mis_req", 32'(bus.data_req), 0);
    nxt; #1;
    chk("lw_mis_req2", 32'(bus.data_req), 0);
    nxt; op = 4'd8; addr = 32'h0000_1001; #1;
    chk("sw_mis_ades", 32'(ades), 1);
    chk("sw_mis_adel", 32'(adel), 0);
    chk("sw_mis_badv", badv, 32'h0000_1001);
    chk("sw_mis_stall", 32'(stall), 0);

    // SW with addr_ok delayed to the third request cycle
    nxt; addr = 32'h0000_2000; sdata = 32'hDEAD_BEEF; #1;
    chk("sw_c0_stall", 32'(stall), 1);
    for (int i = 0; i < 3; i++) begin
      nxt; bus.data_addr_ok = (i == 2); #1;
      chk("sw_hold_req", 32'(bus.data_req), 1);
      chk("sw_hold_addr", bus.data_addr, 32'h0000_2000);
      chk("sw_hold_wstrb", 32'(bus.data_wstrb), 32'hF);
      chk("sw_hold_wdata", bus.data_wdata, 32'hDEAD_BEEF);
    end
    nxt; bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; #1;
    chk("sw_wait_req", 32'(bus.data_req), 0);
    chk("sw_wait_stall", 32'(stall), 1);
    nxt; bus.data_data_ok = 1'b0; #1;
    for (int i = 0; i < 2; i++) begin
      chk("sw_hold_done", 32'(done), 1);
      chk("sw_noreissue", 32'(bus.data_req), 0);
      chk("sw_done_stall", 32'(stall), 0);
      nxt; #1;
    end
    adv = 1'b1; #1;
    chk("sw_adv_done", 32'(done), 1);
    nxt; adv = 1'b0; op = 4'd0; #1;
    chk("sw_idle_done", 32'(done), 0);

    // flush in WAIT, next LW queued behind the cancelled response
    nxt; op = 4'd5; addr = 32'h0000_3000; #1;
    nxt; bus.data_addr_ok = 1'b1; #1;
    nxt; bus.data_addr_ok = 1'b0; flush = 1'b1; #1;
    chk("fl_wait_stall", 32'(stall), 1);
    nxt; flush = 1'b0; addr = 32'h0000_3004; #1;
    chk("fl_q_stall", 32'(stall), 1);
    chk("fl_q_req", 32'(bus.data_req), 0);
    chk("fl_q_done", 32'(done), 0);
    nxt; bus.data_data_ok = 1'b1; bus.data_rdata = 32'hBAD0_BAD0; #1;
    chk("fl_dok_done", 32'(done), 0);
    chk("fl_dok_req", 32'(bus.data_req), 0);
    chk("fl_dok_stall", 32'(stall), 1);
    nxt; bus.data_addr_ok = 1'b1; bus.data_rdata = 32'h1122_3344; #1;
    chk("fl_lw_req", 32'(bus.data_req), 1);
    chk("fl_lw_addr", bus.data_addr, 32'h0000_3004);
    chk("fl_lw_done", 32'(done), 0);
    nxt; bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
    adv = 1'b1; #1;
    chk("fl_lw2_done", 32'(done), 1);
    chk("fl_lw2_ld", ld, 32'h1122_3344);

    // flush in REQ: request held until addr_ok, no stall once cancelled
    nxt; adv = 1'b0; op = 4'd3; addr = 32'h0000_4002; #1;
    nxt; flush = 1'b1; #1;
    chk("flr_c1_req", 32'(bus.data_req), 1);
    nxt; flush = 1'b0; op = 4'd0; bus.data_addr_ok = 1'b1; #1;
    chk("flr_c2_req", 32'(bus.data_req), 1);
    chk("flr_c2_stall", 32'(stall), 0);
    nxt; bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; #1;
    chk("flr_c3_req", 32'(bus.data_req), 0);
    chk("flr_c3_done", 32'(done), 0);
    nxt; bus.data_data_ok = 1'b0; #1;
    chk("flr_c4_done", 32'(done), 0);
    chk("flr_c4_ld", ld, 32'h1122_3344);

    // reset while waiting for data
    nxt; op = 4'd5; addr = 32'h0000_5000; #1;
    nxt; bus.data_addr_ok = 1'b1; #1;
    nxt; bus.data_addr_ok = 1'b0; rst = 1'b0; op = 4'd0; #1;
    nxt; #1;
    chk_zero("mrst");
    rst = 1'b1;

    // LH 0x6002 with same-cycle addr_ok/data_ok
    nxt; op = 4'd3; addr = 32'h0000_6002; #1;
    chk("lh_c0_stall", 32'(stall), 1);
    nxt; bus.data_addr_ok = 1'b1; bus.data_data_ok = 1'b1;
    bus.data_rdata = 32'h8001_7FFF; #1;
    chk("lh_req", 32'(bus.data_req), 1);
    chk("lh_size", 32'(bus.data_size), 1);
    nxt; bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
    adv = 1'b1; #1;
    chk("lh_done", 32'(done), 1);
    chk("lh_ld", ld, 32'hFFFF_8001);
    nxt; adv = 1'b0; op = 4'd0; #1;
    chk("lh_idle", 32'(done), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
